// File: rtl/brk_record_writer.sv
// Breakdown-event capture: timestamps each accepted comparator edge and writes a
// 4-word record into RAM port A. Optional input debounce under `BRK_DEBOUNCE_EN`.
module brk_record_writer #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DEB_CYC = 4
) (
  input  logic              CLK_25M,
  input  logic              rst_n,
  input  logic              brk_in,
  input  logic [15:0]       volt,
  input  logic              volt_vld,
  input  logic              arm,
  input  logic              clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_wren,
  output logic [ADDR_W-2:0] rec_cnt,
  output logic              full,
  output logic              busy,
  output logic              missed
);

  localparam int unsigned       MaxRec    = 2 ** (ADDR_W - 2);
  localparam logic [ADDR_W-2:0] MaxRecCnt = (ADDR_W - 1)'(MaxRec);
  localparam logic [ADDR_W-2:0] LastRec   = (ADDR_W - 1)'(MaxRec - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StWHdr,
    StWTsh,
    StWTsl,
    StWVolt,
    StFull
  } state_e;

  state_e state_q, state_d;

  logic [1:0]        sync_q;
  logic              accept;
  logic [31:0]       ts_q;
  logic [15:0]       vlat_q;
  logic [31:0]       ts_snap_q;
  logic [15:0]       volt_snap_q;
  logic              start;
  logic [ADDR_W-2:0] rec_cnt_q, rec_cnt_d;
  logic              missed_q, missed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-3:0] slot;

  always_ff @(posedge CLK_25M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], brk_in};
    end
  end

`ifdef BRK_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEB_CYC + 1);

  logic [DebW-1:0] deb_cnt_q;

  // Counter saturates at DEB_CYC so a held-high input yields a single event.
  always_ff @(posedge CLK_25M or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
    end else if (!sync_q[1]) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q != DebW'(DEB_CYC)) begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign accept = sync_q[1] && (deb_cnt_q == DebW'(DEB_CYC - 1));
`else
  logic prev_q;
  logic unused_deb;

  always_ff @(posedge CLK_25M or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_q[1];
    end
  end

  assign accept     = sync_q[1] & ~prev_q;
  assign unused_deb = ^DEB_CYC;
`endif

  always_ff @(posedge CLK_25M or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      vlat_q      <= '0;
      ts_snap_q   <= '0;
      volt_snap_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (volt_vld) begin
        vlat_q <= volt;
      end
      // Snapshot only when a record actually starts; dropped edges leave it alone.
      if (start) begin
        ts_snap_q   <= ts_q;
        volt_snap_q <= vlat_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (accept) begin
          state_d = StWHdr;
          start   = 1'b1;
        end
      end
      StWHdr:  state_d = StWTsh;
      StWTsh:  state_d = StWTsl;
      StWTsl:  state_d = StWVolt;
      StWVolt: state_d = (rec_cnt_q == LastRec) ? StFull : StArmed;
      StFull:  state_d = StFull;
      default: state_d = StIdle;
    endcase
    if (clr) begin
      state_d = StIdle;
      start   = 1'b0;
    end
  end

  always_comb begin
    rec_cnt_d = rec_cnt_q;
    missed_d  = missed_q;
    if (clr) begin
      rec_cnt_d = '0;
      missed_d  = 1'b0;
    end else begin
      if (state_q == StWVolt) begin
        rec_cnt_d = rec_cnt_q + 1'b1;
      end
      if (accept && (state_q != StArmed)) begin
        missed_d = 1'b1;
      end
    end
  end

  assign slot = rec_cnt_q[ADDR_W-3:0];

  // Port A word is registered from the next state so it appears in E+1..E+4.
  always_comb begin
    wren_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    case (state_d)
      StWHdr: begin
        wren_d = 1'b1;
        addr_d = {slot, 2'd0};
        data_d = {4'hB, 12'(rec_cnt_q)};
      end
      StWTsh: begin
        wren_d = 1'b1;
        addr_d = {slot, 2'd1};
        data_d = ts_snap_q[31:16];
      end
      StWTsl: begin
        wren_d = 1'b1;
        addr_d = {slot, 2'd2};
        data_d = ts_snap_q[15:0];
      end
      StWVolt: begin
        wren_d = 1'b1;
        addr_d = {slot, 2'd3};
        data_d = volt_snap_q;
      end
      default: begin
        wren_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_25M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rec_cnt_q <= '0;
      missed_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      missed_q  <= missed_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign ram_wren = wren_q;
  assign rec_cnt  = rec_cnt_q;
  assign full     = (rec_cnt_q == MaxRecCnt);
  assign missed   = missed_q;
  assign busy     = (state_q == StWHdr) || (state_q == StWTsh) ||
                    (state_q == StWTsl) || (state_q == StWVolt);

endmodule

// File: tb/tb_brk_record_writer.sv
// Directed bench for brk_record_writer (default build, ADDR_W=10).
module tb_brk_record_writer;

  logic        CLK_25M;
  logic        rst_n;
  logic        brk_in;
  logic [15:0] volt;
  logic        volt_vld;
  logic        arm;
  logic        clr;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [8:0]  rec_cnt;
  logic        full;
  logic        busy;
  logic        missed;

  int n_cmp = 0;
  int n_bad = 0;

  brk_record_writer #(
    .ADDR_W (10),
    .DEB_CYC(4)
  ) dut (
    .CLK_25M (CLK_25M),
    .rst_n   (rst_n),
    .brk_in  (brk_in),
    .volt    (volt),
    .volt_vld(volt_vld),
    .arm     (arm),
    .clr     (clr),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_wren(ram_wren),
    .rec_cnt (rec_cnt),
    .full    (full),
    .busy    (busy),
    .missed  (missed)
  );

  initial begin
    CLK_25M = 1'b0;
    forever #20 CLK_25M = ~CLK_25M;
  end

  // Cycle index aligned with the timestamp counter: both 0 at reset, +1 per edge.
  int unsigned cyc;
  always @(posedge CLK_25M or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [9:0]  log_addr[$];
  logic [15:0] log_data[$];
  int unsigned log_cyc[$];
  int          busy_cnt = 0;

  always @(negedge CLK_25M) begin
    if (rst_n) begin
      if (ram_wren) begin
        log_addr.push_back(ram_addr);
        log_data.push_back(ram_data);
        log_cyc.push_back(cyc);
      end
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_25M);
  endtask

  task automatic do_arm();
    @(negedge CLK_25M) arm = 1'b1;
    @(negedge CLK_25M) arm = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge CLK_25M) clr = 1'b1;
    @(negedge CLK_25M) clr = 1'b0;
  endtask

  task automatic pulse(input int hi, output int unsigned c);
    @(negedge CLK_25M);
    brk_in = 1'b1;
    c = cyc;
    repeat (hi) @(negedge CLK_25M);
    brk_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; brk_in = 1'b0; volt = '0; volt_vld = 1'b0; arm = 1'b0; clr = 1'b0;
    tick(3);
    n_cmp++; if (ram_addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr got %0h want 0", ram_addr); end
    n_cmp++; if (ram_data !== 16'd0) begin n_bad++; $display("FAIL reset_data got %0h want 0", ram_data); end
    n_cmp++; if (ram_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren got %b want 0", ram_wren); end
    n_cmp++; if (rec_cnt !== 9'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", rec_cnt); end
    n_cmp++; if ({full, busy, missed} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got %b want 000", {full, busy, missed});
    end
    rst_n = 1'b1;
    tick(3);
    n_cmp++; if ({ram_wren, busy} !== 2'b00) begin
      n_bad++; $display("FAIL idle_after_reset got %b want 00", {ram_wren, busy});
    end
  endtask

  task automatic test_single_record();
    int unsigned c;
    int n0, b0;
    logic [31:0] ts_exp;
    n0 = log_addr.size(); b0 = busy_cnt;
    do_arm();
    @(negedge CLK_25M) begin volt = 16'h1234; volt_vld = 1'b1; end
    @(negedge CLK_25M) begin volt = 16'hFFFF; volt_vld = 1'b0; end
    pulse(1, c);
    tick(10);
    ts_exp = c + 2;
    n_cmp++; if (log_addr.size() - n0 !== 4) begin
      n_bad++; $display("FAIL rec1_nwrites got %0d want 4", log_addr.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (log_addr[n0+i] !== 10'(i)) begin
          n_bad++; $display("FAIL rec1_addr%0d got %0d want %0d", i, log_addr[n0+i], i);
        end
      end
      n_cmp++; if (log_data[n0] !== 16'hB000) begin n_bad++; $display("FAIL rec1_hdr got %h want B000", log_data[n0]); end
      n_cmp++; if (log_data[n0+1] !== ts_exp[31:16]) begin
        n_bad++; $display("FAIL rec1_tshi got %h want %h", log_data[n0+1], ts_exp[31:16]);
      end
      n_cmp++; if (log_data[n0+2] !== ts_exp[15:0]) begin
        n_bad++; $display("FAIL rec1_tslo got %h want %h", log_data[n0+2], ts_exp[15:0]);
      end
      n_cmp++; if (log_data[n0+3] !== 16'h1234) begin
        n_bad++; $display("FAIL rec1_volt got %h want 1234", log_data[n0+3]);
      end
      n_cmp++; if (log_cyc[n0] !== c + 3) begin
        n_bad++; $display("FAIL rec1_latency got cyc %0d want %0d", log_cyc[n0], c + 3);
      end
    end
    n_cmp++; if (rec_cnt !== 9'd1) begin n_bad++; $display("FAIL rec1_cnt got %0d want 1", rec_cnt); end
    n_cmp++; if (busy_cnt - b0 !== 4) begin n_bad++; $display("FAIL rec1_busy got %0d want 4", busy_cnt - b0); end
    n_cmp++; if (missed !== 1'b0) begin n_bad++; $display("FAIL rec1_missed got %b want 0", missed); end
  endtask

  task automatic test_fill();
    int unsigned c;
    int n0;
    do_clr();
    do_arm();
    n0 = log_addr.size();
    for (int k = 0; k < 256; k++) begin
      pulse(1, c);
      tick(9);
    end
    tick(4);
    n_cmp++; if (log_addr.size() - n0 !== 1024) begin
      n_bad++; $display("FAIL fill_nwrites got %0d want 1024", log_addr.size() - n0);
    end else begin
      n_cmp++; if (log_addr[n0+1020] !== 10'd1020) begin
        n_bad++; $display("FAIL fill_last_base got %0d want 1020", log_addr[n0+1020]);
      end
      n_cmp++; if (log_data[n0+1020] !== 16'hB0FF) begin
        n_bad++; $display("FAIL fill_last_hdr got %h want B0FF", log_data[n0+1020]);
      end
      n_cmp++; if (log_addr[n0+1023] !== 10'd1023) begin
        n_bad++; $display("FAIL fill_last_addr got %0d want 1023", log_addr[n0+1023]);
      end
    end
    n_cmp++; if (rec_cnt !== 9'd256) begin n_bad++; $display("FAIL fill_cnt got %0d want 256", rec_cnt); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got %b want 1", full); end
    n_cmp++; if (missed !== 1'b0) begin n_bad++; $display("FAIL fill_missed_early got %b want 0", missed); end
    n0 = log_addr.size();
    do_arm();
    pulse(1, c);
    tick(10);
    n_cmp++; if (log_addr.size() - n0 !== 0) begin
      n_bad++; $display("FAIL full_nowrite got %0d want 0", log_addr.size() - n0);
    end
    n_cmp++; if ({missed, full} !== 2'b11) begin
      n_bad++; $display("FAIL full_missed got %b want 11", {missed, full});
    end
  endtask

  task automatic test_double_edge();
    int unsigned c;
    int n0;
    do_clr();
    n_cmp++; if ({full, missed, rec_cnt} !== 11'd0) begin
      n_bad++; $display("FAIL clr_from_full got %b want 0", {full, missed, rec_cnt});
    end
    do_arm();
    n0 = log_addr.size();
    pulse(1, c);
    @(negedge CLK_25M) brk_in = 1'b1;
    @(negedge CLK_25M) brk_in = 1'b0;
    tick(10);
    n_cmp++; if (log_addr.size() - n0 !== 4) begin
      n_bad++; $display("FAIL dbl_nwrites got %0d want 4", log_addr.size() - n0);
    end
    n_cmp++; if (rec_cnt !== 9'd1) begin n_bad++; $display("FAIL dbl_cnt got %0d want 1", rec_cnt); end
    n_cmp++; if (missed !== 1'b1) begin n_bad++; $display("FAIL dbl_missed got %b want 1", missed); end
  endtask

  task automatic test_edge_at_volt();
    int unsigned c;
    int n0;
    do_clr();
    do_arm();
    n0 = log_addr.size();
    pulse(1, c);
    tick(2);
    @(negedge CLK_25M) brk_in = 1'b1;
    @(negedge CLK_25M) brk_in = 1'b0;
    tick(12);
    n_cmp++; if (log_addr.size() - n0 !== 4) begin
      n_bad++; $display("FAIL volt_edge_nwrites got %0d want 4", log_addr.size() - n0);
    end
    n_cmp++; if ({missed, rec_cnt} !== {1'b1, 9'd1}) begin
      n_bad++; $display("FAIL volt_edge_state got missed=%b cnt=%0d want 1/1", missed, rec_cnt);
    end
  endtask

  task automatic test_held_high();
    int unsigned c;
    int n0;
    do_clr();
    do_arm();
    n0 = log_addr.size();
    pulse(20, c);
    tick(10);
    n_cmp++; if (log_addr.size() - n0 !== 4) begin
      n_bad++; $display("FAIL held_nwrites got %0d want 4", log_addr.size() - n0);
    end
    n_cmp++; if ({missed, rec_cnt} !== {1'b0, 9'd1}) begin
      n_bad++; $display("FAIL held_state got missed=%b cnt=%0d want 0/1", missed, rec_cnt);
    end
  endtask

  task automatic test_clr_mid();
    int unsigned c;
    int n0;
    do_clr();
    do_arm();
    n0 = log_addr.size();
    for (int k = 0; k < 2; k++) begin
      pulse(1, c);
      tick(9);
    end
    pulse(1, c);
    tick(2);
    @(negedge CLK_25M) clr = 1'b1;
    @(negedge CLK_25M);
    n_cmp++; if (ram_wren !== 1'b0) begin n_bad++; $display("FAIL clr_mid_wren got %b want 0", ram_wren); end
    n_cmp++; if ({rec_cnt, full, missed, busy} !== 12'd0) begin
      n_bad++; $display("FAIL clr_mid_state got cnt=%0d f=%b m=%b b=%b want 0", rec_cnt, full, missed, busy);
    end
    clr = 1'b0;
    tick(10);
    n_cmp++; if (log_addr.size() - n0 !== 10) begin
      n_bad++; $display("FAIL clr_mid_nwrites got %0d want 10", log_addr.size() - n0);
    end else begin
      n_cmp++; if (log_addr[n0+9] !== 10'd9) begin
        n_bad++; $display("FAIL clr_mid_tsh_addr got %0d want 9", log_addr[n0+9]);
      end
    end
    do_arm();
    pulse(1, c);
    tick(10);
    n_cmp++; if (log_addr.size() - n0 !== 14) begin
      n_bad++; $display("FAIL clr_mid_rearm got %0d want 14", log_addr.size() - n0);
    end else begin
      n_cmp++; if ({log_addr[n0+10], log_data[n0+10]} !== {10'd0, 16'hB000}) begin
        n_bad++; $display("FAIL clr_mid_restart got a=%0d d=%h want 0/B000", log_addr[n0+10], log_data[n0+10]);
      end
    end
    n_cmp++; if (rec_cnt !== 9'd1) begin n_bad++; $display("FAIL clr_mid_cnt got %0d want 1", rec_cnt); end
  endtask

  task automatic test_no_arm();
    int unsigned c;
    int n0;
    do_clr();
    n_cmp++; if (ram_addr !== 10'd3) begin n_bad++; $display("FAIL addr_hold got %0d want 3", ram_addr); end
    n0 = log_addr.size();
    pulse(1, c);
    tick(10);
    n_cmp++; if (log_addr.size() - n0 !== 0) begin
      n_bad++; $display("FAIL noarm_nwrites got %0d want 0", log_addr.size() - n0);
    end
    n_cmp++; if (missed !== 1'b1) begin n_bad++; $display("FAIL noarm_missed got %b want 1", missed); end
    @(negedge CLK_25M) begin arm = 1'b1; clr = 1'b1; end
    @(negedge CLK_25M) begin arm = 1'b0; clr = 1'b0; end
    n_cmp++; if (missed !== 1'b0) begin n_bad++; $display("FAIL armclr_missed got %b want 0", missed); end
    pulse(1, c);
    tick(10);
    n_cmp++; if (log_addr.size() - n0 !== 0) begin
      n_bad++; $display("FAIL armclr_idle_nwrites got %0d want 0", log_addr.size() - n0);
    end
    n_cmp++; if (missed !== 1'b1) begin n_bad++; $display("FAIL armclr_idle_missed got %b want 1", missed); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_record();
    test_fill();
    test_double_edge();
    test_edge_at_volt();
    test_held_high();
    test_clr_mid();
    test_no_arm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
